// File: rtl/pipelined_add_sub_pkg.sv
// ---------------------------------------------------------------------------
// adder_pkg
// Shared definitions for the pipelined adder/subtractor.
//   OP_ADD / OP_SUB : encoding of the Sub input (0 = add, 1 = subtract)
//   chunk_width()   : width of one carry chunk, i.e. WIDTH / STAGES
//   params_ok()     : true when WIDTH splits into STAGES equal chunks and
//                     STAGES lies in 1..WIDTH; the top refuses to elaborate
//                     otherwise
// ---------------------------------------------------------------------------
package adder_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Guarded against stages == 0 so a bad parameter reaches the
    // elaboration check instead of dying on a divide by zero.
    function automatic int chunk_width(input int width, input int stages);
        return (stages > 0) ? (width / stages) : width;
    endfunction

    function automatic bit params_ok(input int width, input int stages);
        return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/pipelined_add_sub_if.sv
// ---------------------------------------------------------------------------
// pipelined_add_sub_if
// Operand and result handshake bundle of the pipelined adder/subtractor.
//   in_valid/in_ready   : operand handshake (A, B, Cin, Sub)
//   out_valid/out_ready : result handshake (Sum, Cout, Ovf)
// Modports:
//   master : the side that supplies operands and consumes results
//   slave  : the adder itself
// ---------------------------------------------------------------------------
interface pipelined_add_sub_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             Sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Sum;
    logic             Cout;
    logic             Ovf;

    modport master (
        output in_valid, A, B, Cin, Sub, out_ready,
        input  in_ready, out_valid, Sum, Cout, Ovf
    );

    modport slave (
        input  in_valid, A, B, Cin, Sub, out_ready,
        output in_ready, out_valid, Sum, Cout, Ovf
    );
endinterface

// File: rtl/pipelined_add_sub_add_chunk.sv
// ---------------------------------------------------------------------------
// add_chunk
// Combinational CHUNK-bit ripple adder, the parametrised form of the old
// 4-bit FA4 block.
//   a, b : chunk operands
//   ci   : carry into bit 0
//   s    : chunk sum
//   co   : carry out of the top bit
// ---------------------------------------------------------------------------
module add_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co
);

    logic [CHUNK:0] carry;

    // Plain full-adder ripple: each bit generates when both operands are set
    // and propagates the incoming carry when exactly one is set.
    always_comb begin
        carry[0] = ci;
        s        = '0;
        for (int i = 0; i < CHUNK; i++) begin
            s[i]       = a[i] ^ b[i] ^ carry[i];
            carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
    end

    assign co = carry[CHUNK];

endmodule

// File: rtl/pipelined_add_sub.sv
// ---------------------------------------------------------------------------
// pipelined_add_sub
// WIDTH-bit add/subtract split into STAGES carry chunks, one chunk per
// pipeline stage, one operation per cycle.
//   clk : rising-edge clock
//   rst : synchronous active-high reset, discards everything in flight
//   bus : operand/result handshakes (slave side)
//         Sub=0 -> Sum = A + B + Cin ; Sub=1 -> Sum = A - B (Cin ignored)
//         Cout = carry out of bit WIDTH-1 (1 = no borrow when subtracting)
//         Ovf  = two's-complement overflow
// ---------------------------------------------------------------------------
module pipelined_add_sub
    import adder_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input logic                clk,
    input logic                rst,
    pipelined_add_sub_if.slave bus
);

    localparam int CHUNK = chunk_width(WIDTH, STAGES);
    localparam int LAST  = STAGES - 1;

    if (!params_ok(WIDTH, STAGES)) begin : g_param_check
        $fatal(1, "pipelined_add_sub: WIDTH must be a multiple of STAGES and STAGES in 1..WIDTH");
    end

    // Stage inputs: index k is what stage k sees this cycle
    logic [WIDTH-1:0] a_in   [STAGES];
    logic [WIDTH-1:0] b_in   [STAGES];
    logic [WIDTH-1:0] s_in   [STAGES];
    logic             c_in   [STAGES];
    logic             v_in   [STAGES];

    // Stage results before registering
    logic [CHUNK-1:0] chunk_s  [STAGES];
    logic             chunk_co [STAGES];
    logic [WIDTH-1:0] s_next   [STAGES];
    logic             ovf_next;

    // Stage registers
    logic [WIDTH-1:0] a_q [STAGES];
    logic [WIDTH-1:0] b_q [STAGES];
    logic [WIDTH-1:0] s_q [STAGES];
    logic             c_q [STAGES];
    logic             v_q [STAGES];
    logic             ovf_q;

    logic             en;

    // The whole pipe moves together; it only freezes when a finished result
    // is sitting at the output and nobody is taking it.
    assign en = !v_q[LAST] | bus.out_ready;

    // Stage 0 takes the aligned operands straight from the bus: subtraction
    // becomes A + ~B + 1 here so the op type never has to travel down the
    // pipe. Later stages take whatever the previous stage registered. The
    // valid bit enters as in_valid because registers only load when en=1,
    // which is exactly when in_ready=1.
    always_comb begin
        a_in[0] = bus.A;
        b_in[0] = (bus.Sub == OP_SUB) ? ~bus.B : bus.B;
        c_in[0] = (bus.Sub == OP_SUB) ? 1'b1 : bus.Cin;
        v_in[0] = bus.in_valid;
        s_in[0] = '0;
        for (int k = 1; k < STAGES; k++) begin
            a_in[k] = a_q[k-1];
            b_in[k] = b_q[k-1];
            c_in[k] = c_q[k-1];
            v_in[k] = v_q[k-1];
            s_in[k] = s_q[k-1];
        end
    end

    // One chunk adder per stage, each working on its own slice of the
    // aligned operands with the carry handed over by the previous stage.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        add_chunk #(
            .CHUNK (CHUNK)
        ) u_add_chunk (
            .a  (a_in[k][k*CHUNK +: CHUNK]),
            .b  (b_in[k][k*CHUNK +: CHUNK]),
            .ci (c_in[k]),
            .s  (chunk_s[k]),
            .co (chunk_co[k])
        );
    end

    // Each stage drops its freshly computed chunk into the partial sum while
    // keeping the lower chunks completed by earlier stages.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            s_next[k]                    = s_in[k];
            s_next[k][k*CHUNK +: CHUNK]  = chunk_s[k];
        end
    end

    // Overflow needs the carry into the sign bit. The sign bit's sum is
    // a ^ b ^ carry_in, so that carry is recovered from the last stage's
    // operand and sum bits instead of being brought out of the chunk adder.
    assign ovf_next = chunk_co[LAST] ^
                      (a_in[LAST][WIDTH-1] ^ b_in[LAST][WIDTH-1] ^ chunk_s[LAST][CHUNK-1]);

    // All pipeline registers. Reset empties every stage and zeroes the
    // visible result; otherwise every stage, bubbles included, advances
    // only on en so nothing is overwritten while the output is stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k] <= 1'b0;
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
                c_q[k] <= 1'b0;
            end
            ovf_q <= 1'b0;
        end else if (en) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k] <= v_in[k];
                a_q[k] <= a_in[k];
                b_q[k] <= b_in[k];
                s_q[k] <= s_next[k];
                c_q[k] <= chunk_co[k];
            end
            ovf_q <= ovf_next;
        end
    end

    assign bus.in_ready  = en;
    assign bus.out_valid = v_q[LAST];
    assign bus.Sum       = s_q[LAST];
    assign bus.Cout      = c_q[LAST];
    assign bus.Ovf       = ovf_q;

endmodule

// File: doc/pipelined_add_sub.md
Name: pipelined_add_sub

Overview:
- Parametrised, pipelined successor to the team's 4-bit ripple full adder (FA4).
- Performs WIDTH-bit add or subtract with carry-in, split into STAGES equal carry-chain chunks, one chunk per pipeline stage.
- Throughput is one operation per cycle, with valid/ready handshakes on both sides.
- Used wherever wide adds must meet timing that a single ripple chain cannot.

Parameters:
- WIDTH, 16, operand and result width in bits; must be a multiple of STAGES.
- STAGES, 4, pipeline depth and number of carry chunks; CHUNK = WIDTH/STAGES; legal range 1..WIDTH.

Ports:
- clk  input  1  single clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operands presented
- in_ready  output  1  block accepts operands this cycle
- A  input  WIDTH  operand A
- B  input  WIDTH  operand B
- Cin  input  1  carry-in, used only when Sub=0
- Sub  input  1  0: A+B+Cin; 1: A-B (Cin ignored)
- out_valid  output  1  result present
- out_ready  input  1  downstream accepts result
- Sum  output  WIDTH  result
- Cout  output  1  carry-out; for Sub=1, 1 = no borrow
- Ovf  output  1  signed (two's-complement) overflow

Behaviour:
- Reset (rst=1 at a clock edge): all stage valid bits 0; out_valid=0; Sum=0; Cout=0; Ovf=0. in_ready=1 in the first cycle after reset. A reset mid-operation discards all in-flight operations; no partial result is emitted.
- Subtract is implemented as A + ~B + 1. The inversion and forced carry-in are applied at the input stage, so Sub need not be carried down the pipe.
- Pipeline enable: en = !out_valid | out_ready. When en=0, every stage register holds, including valid bits and partial results.
- in_ready = en, which is combinational from out_valid/out_ready. An input handshake is in_valid & in_ready.
- Stage k (0..STAGES-1) adds chunk k, bits [k*CHUNK +: CHUNK], of the aligned operands, using the carry registered by stage k-1 (stage 0 uses the effective carry-in).
- Each stage registers: its valid bit, the completed low sum chunks, the remaining high operand chunks, and the carry-out.
- Latency: an operation accepted at edge t appears with out_valid=1 after edge t+STAGES, provided no stall occurred. Each stalled cycle adds one cycle.
- Output fields:
  - Sum is the concatenation of all chunk sums.
  - Cout is the carry out of the final chunk.
  - Ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1. It is computed in the last stage.
- Output holding: Sum/Cout/Ovf hold their values while out_valid=1 and out_ready=0. When out_valid=0 they hold their last value and are don't-care for checking.
- Bubbles are not collapsed. An empty stage advances only when en=1. Ordering is strictly FIFO.
- Arithmetic is modulo 2^WIDTH; no saturation.
- STAGES=1 degenerates to a single registered adder with latency 1.
- A simultaneous output pop and input push in the same cycle is legal and sustains full throughput.

Decomposition:
- Shared package adder_pkg holds:
  - localparam function/constant CHUNK = WIDTH/STAGES, plus an elaboration check that WIDTH % STAGES == 0 (fatal if violated);
  - the op encoding constants OP_ADD=1'b0, OP_SUB=1'b1.
- One natural sub-module, add_chunk: a combinational CHUNK-bit adder with inputs a, b, ci and outputs s, co (generalised FA4), instantiated once per stage via generate. Pipeline registers live in the top level.

Test Plan (WIDTH=16, STAGES=4):
- Reset: hold rst=1 for 2 cycles with in_valid=1 -> out_valid=0, Sum=0x0000, Cout=0, Ovf=0, and in_ready=1 after reset releases.
- Basic add: A=0x0006, B=0x0004, Cin=0, Sub=0, out_ready=1 -> after 4 cycles Sum=0x000A, Cout=0, Ovf=0. A=0x0008, B=0x0009, Cin=1 -> Sum=0x0012.
- Carry propagation across all chunks and signed overflow: A=0xFFFF, B=0x0001, Cin=0 -> Sum=0x0000, Cout=1, Ovf=0. A=0x7FFF, B=0x0001 -> Sum=0x8000, Cout=0, Ovf=1.
- Subtract: A=0x0008, B=0x0009, Sub=1, Cin=1 (ignored) -> Sum=0xFFFF, Cout=0. A=0x000E, B=0x0002 -> Sum=0x000C, Cout=1. A=0x8000, B=0x0001 -> Sum=0x7FFF, Ovf=1.
- Back-to-back streaming and stall: push 6 ops on consecutive cycles, then hold out_ready=0 for 5 cycles once the first result appears -> in_ready=0 and Sum stable during the stall. On release, all 6 results emerge in order with none lost or duplicated; random out_ready is then checked against a reference model.
- Reset mid-operation: 3 ops in flight, assert rst for 1 cycle -> out_valid stays 0 and none of the 3 results ever appears. A new op A=0x0010, B=0x0020 -> Sum=0x0030 after 4 cycles.
